simon_seq_ctrl: RTL and testbench
=================================

Name: simon_seq_ctrl

Overview:
- Round controller for the Simon Says game.
- Each round it appends a new 2-bit arrow direction to the stored sequence, then plays the whole sequence to the display one arrow at a time. It then collects the player's button presses and compares each press against the stored arrow.
- It sits between the random-direction source, the button debouncer and the arrow display/comparator datapath, and sequences all three.
- Direction encoding is 2 bits: 0 = up, 1 = right, 2 = down, 3 = left.

Parameters:
- MAX_LEN, 16: maximum sequence length; reaching it and completing it wins the game. Range 2..64.
- SHOW_CYCLES, 25000000: cycles each arrow is displayed; must be >= 1.
- GAP_CYCLES, 12500000: blank cycles after each displayed arrow; must be >= 1.
- TIMEOUT_CYCLES, 250000000: input timeout in cycles; used only with TIMEOUT_EN.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins or restarts a game
- rand_dir  in  2  random direction, sampled in ADD
- btn_valid  in  1  single-cycle pulse, one per debounced press
- btn_dir  in  2  direction of the press, valid with btn_valid
- show_valid  out  1  display arrow active
- show_dir  out  2  arrow being displayed; 0 when show_valid=0
- input_ready  out  1  controller is accepting presses
- round  out  clog2(MAX_LEN+1)  current sequence length
- fail  out  1  sticky game-over flag
- win  out  1  sticky game-won flag

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset, sampled on the rising edge of clock.
- Reset values: state=IDLE; length, play_idx, in_idx and timer = 0; all outputs = 0. Sequence RAM contents are don't-care. Reset wins over every other input in the same cycle.
- Storage: MAX_LEN x 2-bit register array. Written only in ADD.
- State IDLE:
  - start=1 -> length=0, go to ADD.
  - All other inputs are ignored.
- State ADD (1 cycle):
  - mem[length] <= rand_dir; length <= length+1; play_idx <= 0; timer <= 0.
  - Next state SHOW.
- State SHOW:
  - show_valid=1, show_dir=mem[play_idx].
  - timer counts 0..SHOW_CYCLES-1; at terminal count, timer <= 0 and go to GAP.
- State GAP:
  - show_valid=0.
  - timer counts 0..GAP_CYCLES-1. At terminal count:
    - if play_idx == length-1 -> in_idx <= 0, go to INPUT;
    - else play_idx+1 and go to SHOW.
- State INPUT:
  - input_ready=1. Each btn_valid is compared with mem[in_idx]:
    - mismatch -> FAIL.
    - match and in_idx < length-1 -> in_idx+1.
    - match and in_idx == length-1 -> WIN if length == MAX_LEN, else ADD.
  - input_ready drops in the cycle after the accepting press.
- State FAIL: fail=1, held.
- State WIN: win=1, held.
- Restart from FAIL or WIN: start=1 -> clear fail and win, length=0, go to ADD.
- start is ignored in ADD, SHOW, GAP and INPUT.
- btn_valid is ignored (no effect, no compare) in every state other than INPUT.
- Latency:
  - start at edge N -> ADD during cycle N+1 -> show_valid first high in cycle N+2.
  - Each displayed arrow occupies exactly SHOW_CYCLES + GAP_CYCLES cycles.
- round = length, updated the cycle after ADD.
- Width rules:
  - Index and length counters are clog2(MAX_LEN+1) bits.
  - The timer is wide enough for max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).
  - No counter wraps, because all terminal counts are explicit.

Optional Feature:
- Macro: SIMON_INPUT_TIMEOUT_EN.
- Defined:
  - In INPUT, timer counts from entry and is cleared on every accepted press.
  - Reaching TIMEOUT_CYCLES-1 without a press -> FAIL.
  - A press in the same cycle as the timeout is evaluated normally and takes priority over the timeout.
- Undefined:
  - INPUT waits indefinitely.
  - The TIMEOUT_CYCLES parameter exists but is unused.

Test Plan:
All scenarios use MAX_LEN=4, SHOW_CYCLES=3, GAP_CYCLES=2 and a model tracking the rand_dir values sampled in ADD.
- Reset then idle, plus btn_valid pulses -> all outputs 0, round=0, state stays IDLE.
- start with rand_dir=2 -> show_valid high for exactly 3 cycles with show_dir=2, starting 2 cycles after start. Then 2 blank cycles, then input_ready=1 and round=1.
- Correct press 2 -> ADD samples rand_dir=1 and round=2. Playback shows 2 then 1, each for 3 on-cycles and 2 off-cycles, then input_ready=1.
- Round 2 with presses 2 then 3 -> fail=1 the cycle after the second press. input_ready=0, and fail stays high through further button pulses.
- Four correct rounds (sequence 0,1,2,3) -> win=1 after the 4th press of round 4. round=4. A later start clears win and round becomes 1.
- reset asserted mid-SHOW, and start asserted during GAP -> reset forces IDLE with all outputs 0 next cycle; start during GAP has no effect.
- With SIMON_INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=10, no press in INPUT -> fail=1 exactly 10 cycles after input_ready rises.

Source files
------------

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl -- round controller for the Simon Says game.
//
// Each round appends one random 2-bit arrow to the stored sequence, plays
// the whole sequence on the display (SHOW_CYCLES on, GAP_CYCLES blank per
// arrow), then checks the player's presses against the stored arrows.
// Direction encoding: 0 = up, 1 = right, 2 = down, 3 = left.
//
// Optional build macro: SIMON_INPUT_TIMEOUT_EN
//   defined   -> INPUT fails after TIMEOUT_CYCLES cycles without a press
//   undefined -> INPUT waits indefinitely (TIMEOUT_CYCLES only sizes the timer)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   pulse: begin / restart a game (IDLE, FAIL, WIN only)
//   rand_dir     in   random direction, sampled in ADD
//   btn_valid    in   pulse: one debounced press
//   btn_dir      in   direction of the press
//   show_valid   out  arrow display active
//   show_dir     out  displayed arrow, 0 when show_valid = 0
//   input_ready  out  controller is accepting presses
//   round        out  current sequence length
//   fail         out  game over (held until start / reset)
//   win          out  game won (held until start / reset)
//   state_dbg    out  current FSM state encoding
//
// Press handshake: a press is consumed on a rising edge where
// btn_valid = 1 and input_ready = 1; btn_valid while input_ready = 0 is
// dropped without effect. There is no back-pressure toward the debouncer.
module simon_seq_ctrl #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     rand_dir,
    input  logic                           btn_valid,
    input  logic [1:0]                     btn_dir,
    output logic                           show_valid,
    output logic [1:0]                     show_dir,
    output logic                           input_ready,
    output logic [$clog2(MAX_LEN+1)-1:0]   round,
    output logic                           fail,
    output logic                           win,
    output logic [2:0]                     state_dbg
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int AW   = $clog2(MAX_LEN);
    localparam int T1   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4,
        S_FAIL  = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   length, play_idx, in_idx;
    logic [TW-1:0]   timer;
    logic [1:0]      mem [0:(1<<AW)-1];

    logic [LW-1:0]   last_idx;
    logic            show_done, gap_done, last_play, last_in;
    logic            btn_match, timeout_hit;

    assign last_idx  = length - LEN_ONE;
    assign show_done = (timer == SHOW_LAST);
    assign gap_done  = (timer == GAP_LAST);
    assign last_play = (play_idx == last_idx);
    assign last_in   = (in_idx == last_idx);
    assign btn_match = (btn_dir == mem[in_idx[AW-1:0]]);

`ifdef SIMON_INPUT_TIMEOUT_EN
    assign timeout_hit = (timer == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a press in the timeout cycle is judged first
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   state_nxt = S_SHOW;
            S_SHOW:  if (show_done) state_nxt = S_GAP;
            S_GAP:   if (gap_done) state_nxt = last_play ? S_INPUT : S_SHOW;
            S_INPUT: begin
                if (btn_valid) begin
                    if (!btn_match)   state_nxt = S_FAIL;
                    else if (last_in) state_nxt = (length == LEN_MAX) ? S_WIN : S_ADD;
                end else if (timeout_hit) begin
                    state_nxt = S_FAIL;
                end
            end
            S_FAIL:  if (start) state_nxt = S_ADD;
            S_WIN:   if (start) state_nxt = S_ADD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters and sequence length
    always_ff @(posedge clock) begin
        if (reset) begin
            length   <= '0;
            play_idx <= '0;
            in_idx   <= '0;
            timer    <= '0;
        end else begin
            case (state)
                S_IDLE, S_FAIL, S_WIN: if (start) length <= '0;
                S_ADD: begin
                    length   <= length + LEN_ONE;
                    play_idx <= '0;
                    timer    <= '0;
                end
                S_SHOW: timer <= show_done ? '0 : timer + T_ONE;
                S_GAP: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (last_play) in_idx   <= '0;
                        else           play_idx <= play_idx + LEN_ONE;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                S_INPUT: begin
                    if (btn_valid && btn_match && !last_in) in_idx <= in_idx + LEN_ONE;
`ifdef SIMON_INPUT_TIMEOUT_EN
                    if (btn_valid && btn_match) timer <= '0;
                    else if (!timeout_hit)      timer <= timer + T_ONE;
`endif
                end
                default: ;
            endcase
        end
    end

    // Sequence storage: contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (!reset && state == S_ADD) mem[length[AW-1:0]] <= rand_dir;
    end

    // Outputs decoded from state
    always_comb begin
        show_valid  = (state == S_SHOW);
        show_dir    = 2'b00;
        if (state == S_SHOW) show_dir = mem[play_idx[AW-1:0]];
        input_ready = (state == S_INPUT);
        fail        = (state == S_FAIL);
        win         = (state == S_WIN);
        round       = length;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl with MAX_LEN=4, SHOW_CYCLES=3, GAP_CYCLES=2,
// TIMEOUT_CYCLES=10. A cycle table covers reset/idle, rounds 1-2 and a
// failing press; hand sequences cover a full win, restart, reset mid-SHOW,
// start during GAP, and the input timeout (or its absence).
module tb_simon_seq_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] rand_dir;
    logic       btn_valid;
    logic [1:0] btn_dir;
    logic       show_valid;
    logic [1:0] show_dir;
    logic       input_ready;
    logic [2:0] round;
    logic       fail;
    logic       win;
    logic [2:0] state_dbg;

    simon_seq_ctrl #(
        .MAX_LEN(4), .SHOW_CYCLES(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .rand_dir(rand_dir),
        .btn_valid(btn_valid), .btn_dir(btn_dir),
        .show_valid(show_valid), .show_dir(show_dir), .input_ready(input_ready),
        .round(round), .fail(fail), .win(win), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] rd_cur = 2'd0;
    logic [1:0] exp_q[$];      // directions the DUT should have stored

    // Output bundle: {show_valid, show_dir, input_ready, round, fail, win}
    function automatic logic [8:0] outs();
        return {show_valid, show_dir, input_ready, round, fail, win};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: inputs change at negedge, outputs sampled 1 time unit after posedge
    task automatic step(input logic st, input logic bv, input logic [1:0] bd, input logic rst);
        @(negedge clock);
        reset = rst; start = st; btn_valid = bv; btn_dir = bd; rand_dir = rd_cur;
        @(posedge clock);
        #1;
    endtask

    // Call with the DUT in ADD; rd_cur is what ADD stores. Records playback
    // until input_ready and compares it against the expected pattern.
    task automatic run_round(input int n);
        logic [2:0] trace[$];
        logic [2:0] exp_t;
        bit got;
        exp_q.push_back(rd_cur);
        got = 0;
        for (int c = 0; c < 5 * n + 5 && !got; c++) begin
            step(0, 0, 2'd0, 0);
            if (input_ready) got = 1;
            else trace.push_back({show_valid, show_dir});
        end
        check($sformatf("r%0d_ready_reached", n), 32'(got), 32'd1);
        check($sformatf("r%0d_play_len", n), 32'(trace.size()), 32'(5 * n));
        for (int c = 0; c < trace.size() && c < 5 * n; c++) begin
            exp_t = (c % 5 < 3) ? {1'b1, exp_q[c / 5]} : 3'b000;
            check($sformatf("r%0d_play[%0d]", n, c), 32'(trace[c]), 32'(exp_t));
        end
        check($sformatf("r%0d_round", n), 32'(round), 32'(n));
    endtask

    typedef struct packed {
        logic       st;
        logic [1:0] rd;
        logic       bv;
        logic [1:0] bd;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [1:0] rd, input logic bv,
                                input logic [1:0] bd, input logic sv, input logic [1:0] sd,
                                input logic ir, input logic [2:0] rnd, input logic f,
                                input logic w);
        vec_t v;
        v.st = st; v.rd = rd; v.bv = bv; v.bd = bd;
        v.exp = {sv, sd, ir, rnd, f, w};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        //            st rd bv bd   sv sd ir rnd f w
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 0, 0)); // 0 idle, press ignored
        vecs.push_back(mk(0, 0, 1, 3,  0, 0, 0, 0, 0, 0)); // 1 idle, press ignored
        vecs.push_back(mk(1, 2, 0, 0,  0, 0, 0, 0, 0, 0)); // 2 start -> ADD
        vecs.push_back(mk(0, 2, 0, 0,  1, 2, 0, 1, 0, 0)); // 3 ADD stores 2 -> SHOW
        vecs.push_back(mk(0, 0, 0, 0,  1, 2, 0, 1, 0, 0)); // 4 shows stored value
        vecs.push_back(mk(0, 0, 0, 0,  1, 2, 0, 1, 0, 0)); // 5
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0)); // 6 gap
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0)); // 7 gap
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 1, 0, 0)); // 8 input
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 1, 0, 0)); // 9 still waiting
        vecs.push_back(mk(0, 1, 1, 2,  0, 0, 0, 1, 0, 0)); // 10 correct press -> ADD
        vecs.push_back(mk(0, 1, 0, 0,  1, 2, 0, 2, 0, 0)); // 11 ADD stores 1
        vecs.push_back(mk(0, 0, 1, 0,  1, 2, 0, 2, 0, 0)); // 12 press in SHOW ignored
        vecs.push_back(mk(1, 0, 0, 0,  1, 2, 0, 2, 0, 0)); // 13 start in SHOW ignored
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2, 0, 0)); // 14 gap
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2, 0, 0)); // 15 gap
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 2, 0, 0)); // 16 second arrow
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 2, 0, 0)); // 17
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 2, 0, 0)); // 18
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2, 0, 0)); // 19 gap
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 2, 0, 0)); // 20 gap
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 2, 0, 0)); // 21 input
        vecs.push_back(mk(0, 0, 1, 2,  0, 0, 1, 2, 0, 0)); // 22 press 2 ok
        vecs.push_back(mk(0, 0, 1, 3,  0, 0, 0, 2, 1, 0)); // 23 press 3 wrong -> FAIL
        vecs.push_back(mk(0, 0, 1, 1,  0, 0, 0, 2, 1, 0)); // 24 fail held
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0, 2, 1, 0)); // 25 fail held

        reset = 1'b1; start = 1'b0; rand_dir = 2'd0; btn_valid = 1'b0; btn_dir = 2'd0;
        step(0, 0, 2'd0, 1);
        step(0, 0, 2'd0, 1);
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rd_cur = vecs[i].rd;
            step(vecs[i].st, vecs[i].bv, vecs[i].bd, 0);
            check($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Restart from FAIL and win with sequence 0,1,2,3
        exp_q.delete();
        rd_cur = 2'd0;
        step(1, 0, 2'd0, 0);
        check("restart_add", 32'(outs()), 32'd0);
        for (int n = 1; n <= 4; n++) begin
            run_round(n);
            rd_cur = 2'(n);
            for (int k = 0; k < n; k++) begin
                step(0, 1, exp_q[k], 0);
                if (k < n - 1)
                    check($sformatf("r%0d_press%0d_ready", n, k), 32'(input_ready), 32'd1);
            end
            if (n < 4)
                check($sformatf("r%0d_to_add", n), 32'(outs()), 32'({1'b0, 2'd0, 1'b0, 3'(n), 2'b00}));
        end
        check("win_outs", 32'(outs()), 32'({1'b0, 2'd0, 1'b0, 3'd4, 2'b01}));
        step(0, 1, 2'd0, 0);
        step(0, 1, 2'd1, 0);
        check("win_held", 32'(outs()), 32'({1'b0, 2'd0, 1'b0, 3'd4, 2'b01}));

        rd_cur = 2'd3;
        step(1, 0, 2'd0, 0);
        check("win_restart_add", 32'(outs()), 32'd0);
        step(0, 0, 2'd0, 0);
        check("win_restart_show", 32'(outs()), 32'({1'b1, 2'd3, 1'b0, 3'd1, 2'b00}));

        // start during GAP is ignored, reset mid-SHOW clears everything
        step(0, 0, 2'd0, 0);
        step(0, 0, 2'd0, 0);
        step(0, 0, 2'd0, 0);
        step(1, 0, 2'd0, 0);
        check("gap_start_ignored", 32'(outs()), 32'({1'b0, 2'd0, 1'b0, 3'd1, 2'b00}));
        step(0, 0, 2'd0, 0);
        check("gap_then_input", 32'(outs()), 32'({1'b0, 2'd0, 1'b1, 3'd1, 2'b00}));
        rd_cur = 2'd1;
        step(0, 1, 2'd3, 0);
        step(0, 0, 2'd0, 0);
        check("r2_show_before_reset", 32'(outs()), 32'({1'b1, 2'd3, 1'b0, 3'd2, 2'b00}));
        step(0, 0, 2'd0, 1);
        check("reset_mid_show", 32'(outs()), 32'd0);
        check("reset_mid_show_state", 32'(state_dbg), 32'd0);
        step(1, 0, 2'd0, 1);
        check("reset_beats_start", 32'(state_dbg), 32'd0);
        step(0, 0, 2'd0, 0);
        check("idle_after_reset", 32'(outs()), 32'd0);

        // Input timeout behaviour
        exp_q.delete();
        rd_cur = 2'd1;
        step(1, 0, 2'd0, 0);
        run_round(1);
`ifdef SIMON_INPUT_TIMEOUT_EN
        for (int i = 0; i < 9; i++) step(0, 0, 2'd0, 0);
        check("timeout_not_yet", 32'(fail), 32'd0);
        step(0, 0, 2'd0, 0);
        check("timeout_fail", 32'(outs()), 32'({1'b0, 2'd0, 1'b0, 3'd1, 2'b10}));
`else
        for (int i = 0; i < 20; i++) step(0, 0, 2'd0, 0);
        check("no_timeout_wait", 32'(outs()), 32'({1'b0, 2'd0, 1'b1, 3'd1, 2'b00}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
